module_decount_prog: RTL and testbench

//   Programmable down-counter for step-driven timing: counts `step` events

---
 rtl/module_decount_prog.sv | 98 +++++++++
 tb/tb_module_decount_prog.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/module_decount_prog.sv
// Programmable down-counter driven by single-cycle step requests.
// One-shot mode stops and holds at zero. Auto-reload mode restarts from the
// stored reload value and emits a periodic terminal pulse.
module module_decount_prog #(
   parameter int WIDTH  = 8,
   parameter int INIT   = 4,
   parameter int WRAP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              mode,
   input  logic              step,
   output logic [WIDTH-1:0]  count,
   output logic              z,
   output logic              z_pulse,
   output logic [WRAP_W-1:0] wraps
);

   typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

   localparam logic [WIDTH-1:0]  INIT_V   = WIDTH'(INIT);
   localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
   localparam state_t            INIT_ST  = (INIT == 0) ? DONE : RUN;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    count_q, count_d;
   logic [WIDTH-1:0]    reload_q, reload_d;
   logic [WRAP_W-1:0]   wraps_q, wraps_d;
   logic                zp_q, zp_d;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
      return (v == WRAP_MAX) ? v : v + 1'b1;
   endfunction

   // Register all state; reset restores the power-up count and reload value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= INIT_ST;
         count_q  <= INIT_V;
         reload_q <= INIT_V;
         wraps_q  <= '0;
         zp_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         wraps_q  <= wraps_d;
         zp_q     <= zp_d;
      end
   end

   // Next-state logic: clear beats load beats step; lower requests are dropped.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      wraps_d  = wraps_q;
      zp_d     = 1'b0;
      if (clear) begin
         count_d = reload_q;
         wraps_d = '0;
         state_d = (reload_q == '0) ? DONE : RUN;
      end else if (load) begin
         count_d  = load_val;
         reload_d = load_val;
         if (load_val == '0) begin
            // Loading zero is itself a terminal event, whatever the mode.
            state_d = DONE;
            zp_d    = 1'b1;
         end else begin
            state_d = RUN;
         end
      end else if (step && (state_q == RUN)) begin
         if (count_q > WIDTH'(1)) begin
            count_d = count_q - 1'b1;
         end else if (mode) begin
            // reload_q is never zero while in RUN, so the restart is valid.
            count_d = reload_q;
            zp_d    = 1'b1;
            wraps_d = sat_inc(wraps_q);
         end else begin
            count_d = '0;
            state_d = DONE;
            zp_d    = 1'b1;
         end
      end
   end

   assign count   = count_q;
   assign z       = (state_q == DONE);
   assign z_pulse = zp_q;
   assign wraps   = wraps_q;

endmodule

// File: tb/tb_module_decount_prog.sv
// Directed bench for module_decount_prog: one task per scenario with
// hand-computed expectations. A second instance with WRAP_W = 2 covers
// saturation of the reload-event counter.
`timescale 1ns/1ps
module tb_module_decount_prog;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear, load, mode, step;
   logic [7:0] load_val;

   logic [7:0] count_a, count_b;
   logic       z_a, z_b, zp_a, zp_b;
   logic [3:0] wraps_a;
   logic [1:0] wraps_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   module_decount_prog #(.WIDTH(8), .INIT(4), .WRAP_W(4)) dut_a (
      .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
      .mode(mode), .step(step), .count(count_a), .z(z_a), .z_pulse(zp_a),
      .wraps(wraps_a)
   );

   module_decount_prog #(.WIDTH(8), .INIT(4), .WRAP_W(2)) dut_b (
      .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
      .mode(mode), .step(step), .count(count_b), .z(z_b), .z_pulse(zp_b),
      .wraps(wraps_b)
   );

   // Advance one clock and settle just after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; clear = 0; load = 0; mode = 0; step = 0; load_val = 8'd0;
      repeat (2) cyc();
      checks++; if (count_a !== 8'd4) begin errors++; $display("FAIL reset_count got=%0d exp=4", count_a); end
      checks++; if (z_a !== 1'b0) begin errors++; $display("FAIL reset_z got=%b exp=0", z_a); end
      checks++; if (zp_a !== 1'b0) begin errors++; $display("FAIL reset_zpulse got=%b exp=0", zp_a); end
      checks++; if (wraps_a !== 4'd0) begin errors++; $display("FAIL reset_wraps got=%0d exp=0", wraps_a); end
      rst = 1'b1;
      cyc();
      checks++; if (count_a !== 8'd4) begin errors++; $display("FAIL release_count got=%0d exp=4", count_a); end
   endtask

   task automatic test_oneshot();
      logic [7:0] ec [4] = '{8'd3, 8'd2, 8'd1, 8'd0};
      logic       ez [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      mode = 0;
      step = 1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++; if (count_a !== ec[i]) begin errors++; $display("FAIL oneshot_count[%0d] got=%0d exp=%0d", i, count_a, ec[i]); end
         checks++; if (z_a !== ez[i]) begin errors++; $display("FAIL oneshot_z[%0d] got=%b exp=%b", i, z_a, ez[i]); end
         checks++; if (zp_a !== ez[i]) begin errors++; $display("FAIL oneshot_zpulse[%0d] got=%b exp=%b", i, zp_a, ez[i]); end
      end
      cyc();
      step = 0;
      checks++; if (count_a !== 8'd0) begin errors++; $display("FAIL oneshot_hold_count got=%0d exp=0", count_a); end
      checks++; if (z_a !== 1'b1) begin errors++; $display("FAIL oneshot_hold_z got=%b exp=1", z_a); end
      checks++; if (zp_a !== 1'b0) begin errors++; $display("FAIL oneshot_hold_zpulse got=%b exp=0", zp_a); end
   endtask

   task automatic test_autoreload();
      logic [7:0] ec [7] = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2};
      logic       ep [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      mode = 1;
      load = 1; load_val = 8'd3;
      cyc();
      load = 0;
      checks++; if (count_a !== 8'd3 || z_a !== 1'b0) begin errors++; $display("FAIL reload_load got=%0d/z%b exp=3/z0", count_a, z_a); end
      step = 1;
      for (int i = 0; i < 7; i++) begin
         cyc();
         checks++; if (count_a !== ec[i]) begin errors++; $display("FAIL reload_count[%0d] got=%0d exp=%0d", i, count_a, ec[i]); end
         checks++; if (zp_a !== ep[i]) begin errors++; $display("FAIL reload_zpulse[%0d] got=%b exp=%b", i, zp_a, ep[i]); end
         checks++; if (z_a !== 1'b0) begin errors++; $display("FAIL reload_z[%0d] got=%b exp=0", i, z_a); end
      end
      step = 0;
      checks++; if (wraps_a !== 4'd2) begin errors++; $display("FAIL reload_wraps got=%0d exp=2", wraps_a); end
   endtask

   task automatic test_priority();
      mode = 0;
      load = 1; load_val = 8'd5;
      cyc();
      clear = 1; load = 1; load_val = 8'd9; step = 1;
      cyc();
      clear = 0; load = 0;
      checks++; if (count_a !== 8'd5) begin errors++; $display("FAIL prio_count got=%0d exp=5", count_a); end
      checks++; if (z_a !== 1'b0) begin errors++; $display("FAIL prio_z got=%b exp=0", z_a); end
      checks++; if (wraps_a !== 4'd0) begin errors++; $display("FAIL prio_wraps got=%0d exp=0", wraps_a); end
      cyc();
      step = 0;
      checks++; if (count_a !== 8'd4) begin errors++; $display("FAIL prio_step got=%0d exp=4", count_a); end
      clear = 1;
      cyc();
      clear = 0;
      checks++; if (count_a !== 8'd5) begin errors++; $display("FAIL prio_reload_kept got=%0d exp=5", count_a); end
   endtask

   task automatic test_load_zero();
      load = 1; load_val = 8'd0;
      cyc();
      load = 0;
      checks++; if (count_a !== 8'd0 || z_a !== 1'b1) begin errors++; $display("FAIL lz_state got=%0d/z%b exp=0/z1", count_a, z_a); end
      checks++; if (zp_a !== 1'b1) begin errors++; $display("FAIL lz_zpulse got=%b exp=1", zp_a); end
      cyc();
      checks++; if (zp_a !== 1'b0) begin errors++; $display("FAIL lz_zpulse_drop got=%b exp=0", zp_a); end
      mode = 1; step = 1;
      repeat (2) cyc();
      step = 0;
      checks++; if (count_a !== 8'd0 || z_a !== 1'b1 || zp_a !== 1'b0) begin errors++; $display("FAIL lz_step_ignored got=%0d/z%b/p%b exp=0/z1/p0", count_a, z_a, zp_a); end
      clear = 1;
      cyc();
      clear = 0;
      checks++; if (count_a !== 8'd0 || z_a !== 1'b1) begin errors++; $display("FAIL lz_clear_zero got=%0d/z%b exp=0/z1", count_a, z_a); end
   endtask

   task automatic test_async_reset();
      mode = 1;
      load = 1; load_val = 8'd2;
      cyc();
      load = 0; step = 1;
      repeat (2) cyc();
      step = 0;
      checks++; if (count_a !== 8'd2 || wraps_a !== 4'd1) begin errors++; $display("FAIL ar_setup got=%0d/w%0d exp=2/w1", count_a, wraps_a); end
      #2 rst = 1'b0;
      #1;
      checks++; if (count_a !== 8'd4) begin errors++; $display("FAIL ar_count got=%0d exp=4", count_a); end
      checks++; if (z_a !== 1'b0 || wraps_a !== 4'd0) begin errors++; $display("FAIL ar_flags got=z%b/w%0d exp=z0/w0", z_a, wraps_a); end
      #1 rst = 1'b1;
      cyc();
      checks++; if (count_a !== 8'd4) begin errors++; $display("FAIL ar_release got=%0d exp=4", count_a); end
   endtask

   task automatic test_wrap_saturate();
      logic [1:0] ew [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      mode = 1;
      load = 1; load_val = 8'd1;
      cyc();
      load = 0; step = 1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         checks++; if (wraps_b !== ew[i]) begin errors++; $display("FAIL sat_wraps[%0d] got=%0d exp=%0d", i, wraps_b, ew[i]); end
         checks++; if (zp_b !== 1'b1 || count_b !== 8'd1) begin errors++; $display("FAIL sat_pulse[%0d] got=p%b/c%0d exp=p1/c1", i, zp_b, count_b); end
      end
      step = 0;
      cyc();
      checks++; if (zp_b !== 1'b0) begin errors++; $display("FAIL sat_idle got=%b exp=0", zp_b); end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_autoreload();
      test_priority();
      test_load_zero();
      test_async_reset();
      test_wrap_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
